// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state enum, counter width and default timing for the button decoder
package btn_pkg;

    localparam int CNT_W               = 32;
    localparam int DEF_CLK_HZ          = 27000000;
    localparam int DEF_DEBOUNCE_CYCLES = 270000;
    localparam int DEF_LONG_CYCLES     = 27000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } btn_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/pin_debounce.sv
// rtl/pin_debounce.sv - two-flop synchronizer followed by a stability-count debouncer
module pin_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            stable_cnt <= '0;
            dout       <= 1'b0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
            // Any return to the accepted level restarts the stability window.
            if (sync_b != dout) begin
                if (stable_cnt == CNT_LAST) begin
                    dout       <= sync_b;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_press_decoder.sv
// rtl/button_press_decoder.sv - classifies debounced button presses as short or long and reports their length
module button_press_decoder
    import btn_pkg::*;
#(
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ipin,
    output logic             pressed,
    output logic             short_press,
    output logic             long_press,
    output logic             hold_active,
    output logic [CNT_W-1:0] press_len
);

    localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_CYCLES);

    if (CLK_HZ < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
        $error("button_press_decoder: CLK_HZ, DEBOUNCE_CYCLES and LONG_CYCLES must be positive");
    end

    btn_state_t       state;
    logic [CNT_W-1:0] len_cnt;
    logic             db_level;

    pin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ipin),
        .dout (db_level)
    );

    assign pressed = db_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_cnt     <= '0;
            press_len   <= '0;
            hold_active <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            short_press <= 1'b0;
            long_press  <= 1'b0;
            case (state)
                IDLE: begin
                    len_cnt     <= '0;
                    hold_active <= 1'b0;
                    // The first cycle seen high is itself a pressed cycle, so it counts as 1.
                    if (db_level) begin
                        len_cnt     <= CNT_W'(1);
                        hold_active <= (CNT_W'(1) >= LONG_TH);
                        state       <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (db_level) begin
                        len_cnt     <= sat_inc(len_cnt);
                        hold_active <= (sat_inc(len_cnt) >= LONG_TH);
                    end else begin
                        press_len   <= len_cnt;
                        hold_active <= 1'b0;
                        short_press <= (len_cnt < LONG_TH);
                        long_press  <= (len_cnt >= LONG_TH);
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// tb/tb_button_press_decoder.sv - directed self-checking bench for button_press_decoder
module tb_button_press_decoder;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ipin  = 1'b0;
    logic        pressed;
    logic        short_press;
    logic        long_press;
    logic        hold_active;
    logic [31:0] press_len;

    int checks    = 0;
    int errors    = 0;
    int n_short   = 0;
    int n_long    = 0;
    int n_both    = 0;
    int n_pressed = 0;
    int s0, l0, p0;

    button_press_decoder #(
        .CLK_HZ         (1000),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ipin       (ipin),
        .pressed    (pressed),
        .short_press(short_press),
        .long_press (long_press),
        .hold_active(hold_active),
        .press_len  (press_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (short_press) n_short++;
        if (long_press) n_long++;
        if (short_press && long_press) n_both++;
        if (pressed) n_pressed++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s0 = n_short;
        l0 = n_long;
        p0 = n_pressed;
    endtask

    initial begin
        // Reset state
        step(3);
        check("reset_outputs", {pressed, short_press, long_press, hold_active, press_len}, 64'h0);
        rst_n = 1'b1;
        step(2);

        // Short press of 10 cycles: latency and report timing
        snap();
        ipin = 1'b1;
        step(5);
        check("t1_pressed_before", pressed, 1'b0);
        step(1);
        check("t1_pressed_rise", pressed, 1'b1);
        step(4);
        ipin = 1'b0;
        step(5);
        check("t1_pressed_still", pressed, 1'b1);
        step(1);
        check("t1_pressed_fall", pressed, 1'b0);
        check("t1_no_early_pulse", short_press, 1'b0);
        step(1);
        check("t1_short_pulse", short_press, 1'b1);
        check("t1_no_long", long_press, 1'b0);
        check("t1_press_len", press_len, 64'd10);
        step(1);
        check("t1_short_done", short_press, 1'b0);
        step(3);
        check("t1_short_count", n_short - s0, 1);
        check("t1_long_count", n_long - l0, 0);

        // Long press of 30 cycles: hold_active window
        snap();
        ipin = 1'b1;
        step(25);
        check("t2_hold_before", hold_active, 1'b0);
        step(1);
        check("t2_hold_rise", hold_active, 1'b1);
        step(4);
        ipin = 1'b0;
        step(6);
        check("t2_hold_at_fall", hold_active, 1'b1);
        check("t2_no_early_long", long_press, 1'b0);
        step(1);
        check("t2_hold_cleared", hold_active, 1'b0);
        check("t2_long_pulse", long_press, 1'b1);
        check("t2_press_len", press_len, 64'd30);
        step(3);
        check("t2_long_count", n_long - l0, 1);
        check("t2_short_count", n_short - s0, 0);

        // Repeated 3-cycle glitches never pass the debouncer
        snap();
        repeat (5) begin
            ipin = 1'b1;
            step(3);
            ipin = 1'b0;
            step(3);
        end
        step(10);
        check("t3_pressed_never", n_pressed - p0, 0);
        check("t3_no_short", n_short - s0, 0);
        check("t3_no_long", n_long - l0, 0);
        check("t3_press_len_held", press_len, 64'd30);

        // Boundary 19 vs 20 cycles
        snap();
        ipin = 1'b1;
        step(19);
        ipin = 1'b0;
        step(10);
        check("t4_len19", press_len, 64'd19);
        check("t4_len19_short", n_short - s0, 1);
        check("t4_len19_long", n_long - l0, 0);
        snap();
        ipin = 1'b1;
        step(20);
        ipin = 1'b0;
        step(10);
        check("t4_len20", press_len, 64'd20);
        check("t4_len20_short", n_short - s0, 0);
        check("t4_len20_long", n_long - l0, 1);

        // Reset mid-press at count 12
        snap();
        ipin = 1'b1;
        step(18);
        rst_n = 1'b0;
        #1;
        check("t5_async_reset", {pressed, short_press, long_press, hold_active, press_len}, 64'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("t5_pressed_before", pressed, 1'b0);
        step(1);
        check("t5_pressed_rise", pressed, 1'b1);
        check("t5_no_pulse", (n_short - s0) + (n_long - l0), 0);
        ipin = 1'b0;
        step(10);
        check("t5_new_press_len", press_len, 64'd6);
        check("t5_new_press_short", n_short - s0, 1);

        // Forced saturation of the length counter
        snap();
        ipin = 1'b1;
        step(8);
        force dut.len_cnt = 32'hFFFF_FFFE;
        step(1);
        release dut.len_cnt;
        step(3);
        check("t6_counter_saturated", dut.len_cnt, 64'hFFFF_FFFF);
        check("t6_hold_active", hold_active, 1'b1);
        ipin = 1'b0;
        step(10);
        check("t6_press_len", press_len, 64'hFFFF_FFFF);
        check("t6_long_count", n_long - l0, 1);
        check("t6_short_count", n_short - s0, 0);

        check("no_overlap", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
